// File: rtl/pc_img_loader.sv
// Receives an RGB565 image over a UART byte stream (0xAA 0x55 header, then
// MSB-first pixel pairs) and writes each pixel into a frame buffer.
module pc_img_loader #(
    parameter int IMG_WIDTH      = 176,
    parameter int IMG_HEIGHT     = 240,
    parameter int ADDR_WIDTH     = $clog2(IMG_WIDTH*IMG_HEIGHT),
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  abort,
    output logic                  pc_img_fb_we,
    output logic [ADDR_WIDTH-1:0] pc_img_fb_wAddr,
    output logic [15:0]           pc_img_fb_wData,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err
);

    localparam int NUM_PIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int TMO_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIX - 1);
    localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SYNC, PIX_HI, PIX_LO, DONE} state_t;

    state_t                r_state;
    logic [7:0]            r_hi;
    logic [ADDR_WIDTH-1:0] r_pixCnt;
    logic [TMO_W-1:0]      r_tmoCnt;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_wAddr;
    logic [15:0]           r_wData;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic w_payload;
    logic w_timeout;

    assign w_payload = (r_state == PIX_HI) || (r_state == PIX_LO);
    assign w_timeout = !rx_valid && (r_tmoCnt == TMO_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_hi     <= '0;
            r_pixCnt <= '0;
            r_tmoCnt <= '0;
            r_we     <= 1'b0;
            r_wAddr  <= '0;
            r_wData  <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            // Abort wins over a coincident byte; either abort or a stalled
            // link drops the load, leaving already written pixels in place.
            if (w_payload && (abort || w_timeout)) begin
                r_err   <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (rx_valid && !abort && rx_data == 8'hAA) begin
                            r_state <= SYNC;
                        end
                    end
                    SYNC: begin
                        if (abort) begin
                            r_state <= IDLE;
                        end else if (rx_valid) begin
                            if (rx_data == 8'h55) begin
                                r_state  <= PIX_HI;
                                r_pixCnt <= '0;
                                r_tmoCnt <= '0;
                                r_busy   <= 1'b1;
                            end else if (rx_data != 8'hAA) begin
                                r_state <= IDLE;
                            end
                        end
                    end
                    PIX_HI: begin
                        if (rx_valid) begin
                            r_hi     <= rx_data;
                            r_tmoCnt <= '0;
                            r_state  <= PIX_LO;
                        end else begin
                            r_tmoCnt <= r_tmoCnt + 1'b1;
                        end
                    end
                    PIX_LO: begin
                        if (rx_valid) begin
                            r_we     <= 1'b1;
                            r_wAddr  <= r_pixCnt;
                            r_wData  <= {r_hi, rx_data};
                            r_tmoCnt <= '0;
                            r_pixCnt <= r_pixCnt + 1'b1;
                            r_state  <= (r_pixCnt == LAST_ADDR) ? DONE : PIX_HI;
                        end else begin
                            r_tmoCnt <= r_tmoCnt + 1'b1;
                        end
                    end
                    DONE: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign pc_img_fb_we    = r_we;
    assign pc_img_fb_wAddr = r_wAddr;
    assign pc_img_fb_wData = r_wData;
    assign load_busy       = r_busy;
    assign load_done       = r_done;
    assign load_err        = r_err;

endmodule

// File: tb/tb_pc_img_loader.sv
// Bench for pc_img_loader: directed frame scenarios plus random byte traffic,
// compared cycle by cycle against a byte-stream reference model.
module tb_pc_img_loader;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int T   = 50;
    localparam int NP  = W * H;
    localparam int AW  = $clog2(NP);

    logic          clk;
    logic          reset;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          abort;
    logic          pc_img_fb_we;
    logic [AW-1:0] pc_img_fb_wAddr;
    logic [15:0]   pc_img_fb_wData;
    logic          load_busy;
    logic          load_done;
    logic          load_err;

    int total = 0;
    int bad   = 0;

    // Reference model: header hunting flag plus payload byte index.
    bit            mInFrame;
    bit            mSawAA;
    bit            mDonePend;
    int            mByteIdx;
    int            mIdleRun;
    logic [7:0]    mHi;
    logic          mWe;
    logic          mDone;
    logic          mErr;
    logic          mBusy;
    logic [AW-1:0] mAddr;
    logic [15:0]   mData;

    int            obsWr;
    int            obsDone;
    int            obsErr;
    logic [15:0]   firstData;
    logic [AW-1:0] lastWrAddr;

    pc_img_loader #(
        .IMG_WIDTH(W),
        .IMG_HEIGHT(H),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .abort(abort),
        .pc_img_fb_we(pc_img_fb_we),
        .pc_img_fb_wAddr(pc_img_fb_wAddr),
        .pc_img_fb_wData(pc_img_fb_wData),
        .load_busy(load_busy),
        .load_done(load_done),
        .load_err(load_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic logic [7:0] patByte(input int k);
        return 8'(8'h12 + 8'(k) * 8'h22);
    endfunction

    function void modelReset();
        mInFrame  = 1'b0;
        mSawAA    = 1'b0;
        mDonePend = 1'b0;
        mByteIdx  = 0;
        mIdleRun  = 0;
        mHi       = '0;
        mWe       = 1'b0;
        mDone     = 1'b0;
        mErr      = 1'b0;
        mBusy     = 1'b0;
        mAddr     = '0;
        mData     = '0;
    endfunction

    function void modelStep(input logic v, input logic [7:0] d, input logic ab);
        mWe   = 1'b0;
        mDone = 1'b0;
        mErr  = 1'b0;
        if (mDonePend) begin
            mDone     = 1'b1;
            mDonePend = 1'b0;
        end else if (mInFrame) begin
            if (ab) begin
                mErr     = 1'b1;
                mInFrame = 1'b0;
            end else if (v) begin
                mIdleRun = 0;
                if (mByteIdx % 2 == 0) begin
                    mHi = d;
                end else begin
                    mWe   = 1'b1;
                    mAddr = AW'(mByteIdx / 2);
                    mData = {mHi, d};
                end
                mByteIdx++;
                if (mByteIdx == 2 * NP) begin
                    mInFrame  = 1'b0;
                    mDonePend = 1'b1;
                end
            end else begin
                mIdleRun++;
                if (mIdleRun == T) begin
                    mErr     = 1'b1;
                    mInFrame = 1'b0;
                end
            end
        end else begin
            if (ab) begin
                mSawAA = 1'b0;
            end else if (v) begin
                if (mSawAA && d == 8'h55) begin
                    mInFrame = 1'b1;
                    mByteIdx = 0;
                    mIdleRun = 0;
                    mSawAA   = 1'b0;
                end else begin
                    mSawAA = (d == 8'hAA);
                end
            end
        end
        mBusy = mInFrame || mDonePend;
    endfunction

    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic ab);
        rx_valid = v;
        rx_data  = d;
        abort    = ab;
        @(posedge clk);
        modelStep(v, d, ab);
        #1;
        checkOutput("we",    32'(pc_img_fb_we),    32'(mWe));
        checkOutput("wAddr", 32'(pc_img_fb_wAddr), 32'(mAddr));
        checkOutput("wData", 32'(pc_img_fb_wData), 32'(mData));
        checkOutput("busy",  32'(load_busy),       32'(mBusy));
        checkOutput("done",  32'(load_done),       32'(mDone));
        checkOutput("err",   32'(load_err),        32'(mErr));
        checkOutput("excl",  32'(pc_img_fb_we) + 32'(load_done) + 32'(load_err) > 1 ? 32'd1 : 32'd0, 32'd0);
        if (pc_img_fb_we === 1'b1) begin
            if (obsWr == 0) firstData = pc_img_fb_wData;
            lastWrAddr = pc_img_fb_wAddr;
            obsWr++;
        end
        if (load_done === 1'b1) obsDone++;
        if (load_err === 1'b1) obsErr++;
    endtask

    task automatic clearCounts();
        obsWr      = 0;
        obsDone    = 0;
        obsErr     = 0;
        firstData  = '0;
        lastWrAddr = '0;
    endtask

    task automatic sendByte(input logic [7:0] d);
        applyStimulus(1'b1, d, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    endtask

    task automatic sendFrame(input bit rnd);
        sendByte(8'hAA);
        sendByte(8'h55);
        for (int k = 0; k < 2 * NP; k++) sendByte(rnd ? 8'($urandom) : patByte(k));
    endtask

    task automatic checkZeroOutputs(input string tag);
        checkOutput({tag, "_we"},    32'(pc_img_fb_we),    32'd0);
        checkOutput({tag, "_wAddr"}, 32'(pc_img_fb_wAddr), 32'd0);
        checkOutput({tag, "_wData"}, 32'(pc_img_fb_wData), 32'd0);
        checkOutput({tag, "_busy"},  32'(load_busy),       32'd0);
        checkOutput({tag, "_done"},  32'(load_done),       32'd0);
        checkOutput({tag, "_err"},   32'(load_err),        32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        abort    = 1'b0;
        modelReset();
        clearCounts();
        #2 reset = 1'b0;
        #1 checkZeroOutputs("rst");
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;

        $display("[TB] full frame");
        clearCounts();
        sendFrame(1'b0);
        idle(3);
        checkOutput("f1_writes", 32'(obsWr), 32'd8);
        checkOutput("f1_first",  32'(firstData), 32'h1234);
        checkOutput("f1_last",   32'(lastWrAddr), 32'd7);
        checkOutput("f1_done",   32'(obsDone), 32'd1);

        $display("[TB] bad header");
        clearCounts();
        sendByte(8'hAA); sendByte(8'h13); sendByte(8'h55); sendByte(8'h00); sendByte(8'h00);
        idle(2);
        checkOutput("bh_writes", 32'(obsWr), 32'd0);
        sendByte(8'hAA); sendByte(8'hAA); sendByte(8'h55);
        for (int k = 0; k < 2 * NP; k++) sendByte(patByte(k));
        idle(3);
        checkOutput("bh_writes2", 32'(obsWr), 32'd8);
        checkOutput("bh_done",    32'(obsDone), 32'd1);

        $display("[TB] timeout");
        clearCounts();
        sendByte(8'hAA); sendByte(8'h55);
        for (int k = 0; k < 5; k++) sendByte(patByte(k));
        idle(T + 5);
        checkOutput("to_writes", 32'(obsWr), 32'd2);
        checkOutput("to_err",    32'(obsErr), 32'd1);
        checkOutput("to_done",   32'(obsDone), 32'd0);

        $display("[TB] abort with byte");
        clearCounts();
        sendByte(8'hAA); sendByte(8'h55);
        for (int k = 0; k < 3; k++) sendByte(patByte(k));
        applyStimulus(1'b1, patByte(3), 1'b1);
        idle(2);
        checkOutput("ab_writes", 32'(obsWr), 32'd1);
        checkOutput("ab_err",    32'(obsErr), 32'd1);
        sendFrame(1'b0);
        idle(3);
        checkOutput("ab_writes2", 32'(obsWr), 32'd9);
        checkOutput("ab_done",    32'(obsDone), 32'd1);

        $display("[TB] reset mid-frame");
        clearCounts();
        sendByte(8'hAA); sendByte(8'h55);
        for (int k = 0; k < 6; k++) sendByte(patByte(k));
        #2 reset = 1'b0;
        #1 checkZeroOutputs("midrst");
        modelReset();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        clearCounts();
        idle(3);
        checkOutput("mr_quiet", 32'(obsDone + obsErr + obsWr), 32'd0);
        sendFrame(1'b0);
        idle(3);
        checkOutput("mr_writes", 32'(obsWr), 32'd8);
        checkOutput("mr_last",   32'(lastWrAddr), 32'd7);

        $display("[TB] back-to-back");
        clearCounts();
        sendFrame(1'b1);
        idle(1);
        sendFrame(1'b1);
        idle(3);
        checkOutput("bb_writes", 32'(obsWr), 32'd16);
        checkOutput("bb_done",   32'(obsDone), 32'd2);

        $display("[TB] random traffic");
        for (int c = 0; c < 3000; c++) begin
            int r;
            int sel;
            logic [7:0] d;
            r = int'($urandom_range(0, 199));
            if (r == 0) begin
                idle(T + 3);
            end else if (r < 4) begin
                sendFrame(1'b1);
            end else begin
                sel = int'($urandom_range(0, 3));
                d = (sel == 0) ? 8'hAA : (sel == 1) ? 8'h55 : 8'($urandom);
                applyStimulus($urandom_range(0, 99) < 40, d, $urandom_range(0, 149) == 0);
            end
        end
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pc_img_loader.md
PC_IMG_LOADER -- requirements
Module: pc_img_loader

Interface
REQ-001 SHALL have parameter IMG_WIDTH, default 176, image width in pixels.
REQ-002 SHALL have parameter IMG_HEIGHT, default 240, image height in pixels.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(IMG_WIDTH*IMG_HEIGHT), frame buffer address width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000, maximum idle clk cycles between payload bytes.
REQ-005 SHALL have port clk, input, 1, single system clock; all logic on rising edge.
REQ-006 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port rx_data, input, 8, received UART byte.
REQ-008 SHALL have port rx_valid, input, 1, one-cycle strobe qualifying rx_data.
REQ-009 SHALL have port abort, input, 1, synchronous request to drop the current load.
REQ-010 SHALL have port pc_img_fb_we, output, 1, frame buffer write enable.
REQ-011 SHALL have port pc_img_fb_wAddr, output, ADDR_WIDTH, frame buffer write address.
REQ-012 SHALL have port pc_img_fb_wData, output, 16, RGB565 pixel.
REQ-013 SHALL have port load_busy, output, 1, high while a frame is being received.
REQ-014 SHALL have port load_done, output, 1, one-cycle pulse on frame completion.
REQ-015 SHALL have port load_err, output, 1, one-cycle pulse on timeout or abort during a load.

Function
REQ-016 SHALL implement states IDLE, SYNC, PIX_HI, PIX_LO, DONE.
REQ-017 IDLE: rx_valid with rx_data=0xAA -> SYNC; any other byte ignored.
REQ-018 SYNC: 0x55 -> PIX_HI with pixel counter cleared to 0; 0xAA -> stay in SYNC; any other byte -> IDLE.
REQ-019 PIX_HI: accepted byte latched as high byte -> PIX_LO.
REQ-020 PIX_LO: accepted byte forms pixel {hi,lo}, MSB byte first.
REQ-021 Write timing: pc_img_fb_we SHALL be high for exactly the one cycle after the low-byte rx_valid, with wAddr = pixel counter and wData = {hi,lo}.
REQ-022 Counter advance: the pixel counter SHALL increment after each write.
REQ-023 Last pixel: when the written address = IMG_WIDTH*IMG_HEIGHT-1, SHALL go to DONE instead of PIX_HI.
REQ-024 DONE: SHALL last one cycle, pulse load_done, then return to IDLE; an rx_valid in DONE is ignored.
REQ-025 pc_img_fb_wAddr and pc_img_fb_wData SHALL hold their last values when we=0.
REQ-026 load_busy SHALL be high in PIX_HI, PIX_LO and DONE, and low in IDLE and SYNC.
REQ-027 Timeout counter: SHALL clear on entry to PIX_HI and on every rx_valid; SHALL count each cycle in PIX_HI/PIX_LO without rx_valid.
REQ-028 Timeout: when the counter reaches TIMEOUT_CYCLES-1, SHALL pulse load_err and go to IDLE; no write occurs; pixels already written stay in memory.
REQ-029 Abort: in PIX_HI/PIX_LO, abort SHALL pulse load_err next cycle and go to IDLE; in IDLE/SYNC it SHALL return to IDLE without load_err.
REQ-030 Abort with byte: abort has priority over a simultaneous rx_valid; that byte is discarded and no write occurs.
REQ-031 Re-sync: a new 0xAA 0x55 header is recognised only from IDLE/SYNC; header bytes inside the payload are treated as pixel data.
REQ-032 we, load_done and load_err SHALL never be high in the same cycle.

Reset
REQ-033 Reset low SHALL immediately force IDLE and clear the hi-byte latch, the pixel counter and the timeout counter.
REQ-034 Reset low SHALL immediately force we=0, wAddr=0, wData=0, load_busy=0, load_done=0 and load_err=0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame; no completion or error pulse follows reset release.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, TIMEOUT_CYCLES=50)
REQ-036 Full frame: bytes AA 55 then 0x12 0x34 ... (16 bytes) -> 8 writes to addresses 0..7, first wData=0x1234, load_done one cycle after the addr-7 write, load_busy low afterward.
REQ-037 Bad header: AA 13 55 00 00 -> no writes, stays IDLE; then AA AA 55 + 16 bytes -> normal frame.
REQ-038 Timeout: header + 5 bytes, then 50 idle cycles -> 2 writes (addr 0,1), load_err pulse, IDLE, no load_done.
REQ-039 Abort with byte: abort coincident with the 4th payload byte's rx_valid -> only addr 0 written, load_err next cycle; a following full frame starts again at addr 0.
REQ-040 Reset mid-frame: reset low after 3 pixels -> all outputs 0 immediately; after release, a full frame writes addresses 0..7.
REQ-041 Back-to-back: two full frames separated by 1 idle cycle -> 16 writes total and two load_done pulses.
